// File: rtl/vga_timing_pkg.sv
// Default VGA raster timing (640x480@60 from a 25 MHz pixel rate) and the
// coordinate type shared by the sync generator and its consumers.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] coord_t;

endpackage : vga_timing_pkg

// File: rtl/px_tick_gen.sv
// Samples the divided pixel clock as data in the clk domain and turns each
// rising edge into a single-clk tick.
module px_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic px_clk,
  output logic tick
);

  logic px_q;

  // NOTE: sequential state uses non-blocking assignments and a synchronous
  // active-low reset, so px_q is 0 for the first cycle after release.
  always_ff @(posedge clk) begin
    if (!rst) px_q <= 1'b0;
    else      px_q <= px_clk;
  end

  assign tick = px_clk & ~px_q;

endmodule : px_tick_gen

// File: rtl/vga_sync_gen.sv
// VGA raster counters and registered sync/blanking decode, clocked by a pixel
// tick derived from px_clk. Define VGA_SYNC_FRAME_START_EN to enable frame_start.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int CNT_W    = vga_timing_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             px_clk,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_width_check
    $error("vga_sync_gen: CNT_W too narrow for the configured raster totals");
  end

  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  px_tick_gen u_px_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .px_clk (px_clk),
    .tick   (tick)
  );

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Decode runs every clk so outputs trail the counters by exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else begin
      hsync    <= ~((h_cnt >= HS_START) && (h_cnt < HS_END));
      vsync    <= ~((v_cnt >= VS_START) && (v_cnt < VS_END));
      video_on <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      x        <= h_cnt;
      y        <= v_cnt;
    end
  end

`ifdef VGA_SYNC_FRAME_START_EN
  // wrap_q marks the tick that returned the raster to (0,0); the decode stage
  // shows (0,0) one cycle later, which is when frame_start fires.
  logic wrap_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_q      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      wrap_q      <= tick & h_last & v_last;
      frame_start <= wrap_q;
    end
  end
`else
  assign frame_start = 1'b0;
`endif

endmodule : vga_sync_gen

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: the stimulus pushes expected raster outputs per cycle for a
// full-size and a shrunken-timing instance; a negedge monitor pops and compares.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int SH_A = 16, SH_FP = 2, SH_S = 4, SH_BP = 2;
  localparam int SV_A = 8,  SV_FP = 2, SV_S = 2, SV_BP = 2;

`ifdef VGA_SYNC_FRAME_START_EN
  localparam logic FS_EN = 1'b1;
`else
  localparam logic FS_EN = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst;
  logic   px_clk;
  coord_t x0, y0, x1, y1;
  logic   hs0, vs0, vo0, fs0;
  logic   hs1, vs1, vo1, fs1;

  vga_sync_gen u_dut_full (
    .clk (clk), .rst (rst), .px_clk (px_clk),
    .hsync (hs0), .vsync (vs0), .video_on (vo0),
    .x (x0), .y (y0), .frame_start (fs0)
  );

  vga_sync_gen #(
    .H_ACTIVE (SH_A), .H_FP (SH_FP), .H_SYNC (SH_S), .H_BP (SH_BP),
    .V_ACTIVE (SV_A), .V_FP (SV_FP), .V_SYNC (SV_S), .V_BP (SV_BP),
    .CNT_W (10)
  ) u_dut_small (
    .clk (clk), .rst (rst), .px_clk (px_clk),
    .hsync (hs1), .vsync (vs1), .video_on (vo1),
    .x (x1), .y (y1), .frame_start (fs1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          dut;
    logic [23:0] exp;
    string       tag;
  } exp_t;

  typedef struct {
    int          dut;
    int          tick;
    logic [23:0] exp;
    string       tag;
  } dir_t;

  exp_t sb[$];
  dir_t dirs[$];
  int   tests = 0;
  int   fails = 0;
  int   mh[2];
  int   mv[2];
  int   tick_idx = 0;

  function automatic logic [23:0] pack(int xv, int yv, logic h, logic v, logic o, logic f);
    return {xv[9:0], yv[9:0], h, v, o, f};
  endfunction

  function automatic int htot(int d);
    return (d == 0) ? (H_ACTIVE + H_FP + H_SYNC + H_BP) : (SH_A + SH_FP + SH_S + SH_BP);
  endfunction

  function automatic int vtot(int d);
    return (d == 0) ? (V_ACTIVE + V_FP + V_SYNC + V_BP) : (SV_A + SV_FP + SV_S + SV_BP);
  endfunction

  function automatic logic [23:0] model_out(int d, int h, int v, logic f);
    int ha, hb, he, va, vb, ve;
    if (d == 0) begin
      ha = H_ACTIVE; hb = H_ACTIVE + H_FP; he = hb + H_SYNC;
      va = V_ACTIVE; vb = V_ACTIVE + V_FP; ve = vb + V_SYNC;
    end else begin
      ha = SH_A; hb = SH_A + SH_FP; he = hb + SH_S;
      va = SV_A; vb = SV_A + SV_FP; ve = vb + SV_S;
    end
    return pack(h, v, !(h >= hb && h < he), !(v >= vb && v < ve), (h < ha) && (v < va), f);
  endfunction

  task automatic check(string name, int d, logic [23:0] got, logic [23:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (dut%0d, cycle %0d): got x=%0d y=%0d hs/vs/vo/fs=%b, required x=%0d y=%0d hs/vs/vo/fs=%b",
               name, d, cyc, got[23:14], got[13:4], got[3:0], exp[23:14], exp[13:4], exp[3:0]);
    end
  endtask

  task automatic push(int c, int d, logic [23:0] e, string tag);
    exp_t item;
    item.cyc = c; item.dut = d; item.exp = e; item.tag = tag;
    sb.push_back(item);
  endtask

  task automatic add_dir(int d, int t, logic [23:0] e, string tag);
    dir_t item;
    item.dut = d; item.tick = t; item.exp = e; item.tag = tag;
    dirs.push_back(item);
  endtask

  // Monitor: compares every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        if (sb[i].cyc < cyc) begin
          tests++;
          fails++;
          $display("FAIL %s (dut%0d): check for cycle %0d missed at cycle %0d",
                   sb[i].tag, sb[i].dut, sb[i].cyc, cyc);
        end else begin
          check(sb[i].tag, sb[i].dut,
                (sb[i].dut == 0) ? {x0, y0, hs0, vs0, vo0, fs0} : {x1, y1, hs1, vs1, vo1, fs1},
                sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      mh[d] = 0;
      mv[d] = 0;
    end
  endtask

  task automatic expect_reset(int c);
    for (int d = 0; d < 2; d++) push(c, d, pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0), "reset_values");
  endtask

  task automatic expect_release(int c);
    for (int d = 0; d < 2; d++) begin
      push(c,     d, pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b0), "after_release");
      push(c + 1, d, pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b0), "after_release_hold");
    end
  endtask

  // One px_clk rise, held high for hi clks then low for lo clks; outputs are
  // expected to hold the new position for span clks starting two clks later.
  task automatic rise(int hi, int lo, int span);
    logic fsw;
    px_clk = 1'b1;
    tick_idx++;
    for (int d = 0; d < 2; d++) begin
      fsw = 1'b0;
      if (mh[d] == htot(d) - 1) begin
        mh[d] = 0;
        if (mv[d] == vtot(d) - 1) begin
          mv[d] = 0;
          fsw   = FS_EN;
        end else begin
          mv[d]++;
        end
      end else begin
        mh[d]++;
      end
      for (int k = 2; k <= span + 1; k++)
        push(cyc + k, d, model_out(d, mh[d], mv[d], (k == 2) ? fsw : 1'b0),
             (d == 0) ? "full_raster" : "small_raster");
    end
    foreach (dirs[i])
      if (dirs[i].tick == tick_idx) push(cyc + 2, dirs[i].dut, dirs[i].exp, dirs[i].tag);
    repeat (hi) wait_cycle();
    px_clk = 1'b0;
    repeat (lo) wait_cycle();
  endtask

  initial begin
    // Hand-computed raster points, indexed by tick count since reset release.
    add_dir(0, 1,   pack(1,   0, 1, 1, 1, 0), "first_tick_x1");
    add_dir(0, 639, pack(639, 0, 1, 1, 1, 0), "last_visible_x");
    add_dir(0, 640, pack(640, 0, 1, 1, 0, 0), "blank_from_640");
    add_dir(0, 655, pack(655, 0, 1, 1, 0, 0), "hsync_before_656");
    add_dir(0, 656, pack(656, 0, 0, 1, 0, 0), "hsync_start_656");
    add_dir(0, 751, pack(751, 0, 0, 1, 0, 0), "hsync_end_751");
    add_dir(0, 752, pack(752, 0, 1, 1, 0, 0), "hsync_off_752");
    add_dir(0, 799, pack(799, 0, 1, 1, 0, 0), "x_max_799");
    add_dir(0, 800, pack(0,   1, 1, 1, 1, 0), "x_wrap_y_inc");
    add_dir(1, 240, pack(0,  10, 1, 0, 0, 0), "small_vsync_start");
    add_dir(1, 287, pack(23, 11, 1, 0, 0, 0), "small_vsync_last");
    add_dir(1, 288, pack(0,  12, 1, 1, 0, 0), "small_vsync_off");
    add_dir(1, 335, pack(23, 13, 1, 1, 0, 0), "small_frame_end");
    add_dir(1, 336, pack(0,   0, 1, 1, 1, FS_EN), "small_frame_wrap");
    add_dir(1, 355, pack(19,  0, 0, 1, 0, 0), "small_hsync_mid");

    rst    = 1'b0;
    px_clk = 1'b0;
    reset_model();
    wait_cycle();
    for (int i = 0; i < 5; i++) begin
      px_clk = ((i % 2) == 0);
      expect_reset(cyc + 1);
      wait_cycle();
    end
    px_clk = 1'b0;
    rst    = 1'b1;
    expect_release(cyc + 1);
    wait_cycle();

    repeat (810) rise(2, 2, 4);

    rise(20, 2, 22);
    rise(2, 2, 4);

    // Drive the small raster to (19,10), inside both sync pulses, then reset.
    for (int n = 0; n < 400; n++) begin
      rise(2, 1, 2);
      if (mh[1] == 19 && mv[1] == 10) break;
    end
    tests++;
    if (!(mh[1] == 19 && mv[1] == 10)) begin
      fails++;
      $display("FAIL mid_reset_target: got x=%0d y=%0d, required x=19 y=10", mh[1], mv[1]);
    end
    rst = 1'b0;
    expect_reset(cyc + 1);
    reset_model();
    wait_cycle();
    rst = 1'b1;
    expect_release(cyc + 1);
    wait_cycle();
    repeat (40) rise(2, 2, 4);

    repeat (8) wait_cycle();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_vga_sync_gen
